// File: rtl/pong_pkg.sv
// Shared pong types and constants: match state, game_state bus and winner
// encodings, and the active video area used by the ball and paddle blocks.
package pong_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SERVE,
      S_PLAY,
      S_PAUSE,
      S_OVER
   } state_t;

   localparam logic [1:0] GS_IDLE  = 2'b00;
   localparam logic [1:0] GS_PLAY  = 2'b01;
   localparam logic [1:0] GS_PAUSE = 2'b10;
   localparam logic [1:0] GS_OVER  = 2'b11;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // SERVE shares the idle code: the ball must stay frozen while serving.
   function automatic logic [1:0] gs_encode(input state_t s);
      case (s)
         S_PLAY:  return GS_PLAY;
         S_PAUSE: return GS_PAUSE;
         S_OVER:  return GS_OVER;
         default: return GS_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Match controller bus: debounced buttons and ball scores in,
// game state, ball restart, serve countdown and winner out.
interface pong_match_ctrl_if #(parameter int CNT_W = 10);

   logic             start_btn;
   logic             pause_btn;
   logic [3:0]       p1_score;
   logic [3:0]       p2_score;
   logic [1:0]       game_state;
   logic             ball_rst_n;
   logic [CNT_W-1:0] serve_cnt;
   logic [1:0]       winner;

   // Drives buttons and scores, observes the controller outputs.
   modport master (
      output start_btn, pause_btn, p1_score, p2_score,
      input  game_state, ball_rst_n, serve_cnt, winner
   );

   // The match controller itself.
   modport slave (
      input  start_btn, pause_btn, p1_score, p2_score,
      output game_state, ball_rst_n, serve_cnt, winner
   );

endinterface

// File: rtl/rise_edge.sv
// Rising-edge detector: keeps one tick of input history and flags a
// 0->1 transition combinationally, so a held input yields one event.
module rise_edge (
   input  logic clk_1ms,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   // Input history register, cleared by synchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_1ms) begin
      if (!reset) d_q <= 1'b0;
      else        d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer: serve delay, pause/resume, match-end detection and
// ball restart, all on the 1 ms tick with registered outputs.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 7,
   parameter int SERVE_MS  = 1000,
   parameter int CNT_W     = 10
) (
   input  logic             clk_1ms,
   input  logic             reset,
   pong_match_ctrl_if.slave bus
);

   if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win_score
      $error("pong_match_ctrl: WIN_SCORE must be 1..15, scores would wrap");
   end
   if (SERVE_MS < 1 || (2 ** CNT_W) <= SERVE_MS) begin : g_bad_serve_ms
      $error("pong_match_ctrl: SERVE_MS must be >= 1 and fit in CNT_W bits");
   end

   localparam logic [3:0]       WIN4      = 4'(WIN_SCORE);
   localparam logic [CNT_W-1:0] SERVE_LD  = CNT_W'(SERVE_MS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       winner_q, winner_d;
   logic [1:0]       gs_q;
   logic             brst_q, brst_d;
   logic [3:0]       p1_q, p1_d, p2_q, p2_d;
   logic             start_rise, pause_rise, sc_evt;

   rise_edge u_start_edge (
      .clk_1ms (clk_1ms),
      .reset   (reset),
      .d       (bus.start_btn),
      .rise    (start_rise)
   );

   rise_edge u_pause_edge (
      .clk_1ms (clk_1ms),
      .reset   (reset),
      .d       (bus.pause_btn),
      .rise    (pause_rise)
   );

   assign sc_evt = (bus.p1_score != p1_q) | (bus.p2_score != p2_q);

   // Next-state and next-output logic for the match sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      winner_d = winner_q;
      brst_d   = 1'b1;
      p1_d     = bus.p1_score;
      p2_d     = bus.p2_score;
      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d = S_SERVE;
               cnt_d   = SERVE_LD;
            end
         end
         S_SERVE: begin
            if (cnt_q == '0) state_d = S_PLAY;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_PLAY: begin
            // A score always wins over a simultaneous pause request.
            if (sc_evt && bus.p1_score >= WIN4) begin
               state_d  = S_OVER;
               winner_d = WIN_P1;
            end else if (sc_evt && bus.p2_score >= WIN4) begin
               state_d  = S_OVER;
               winner_d = WIN_P2;
            end else if (sc_evt) begin
               state_d = S_SERVE;
               cnt_d   = SERVE_LD;
            end else if (pause_rise) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (pause_rise) state_d = S_PLAY;
         end
         S_OVER: begin
            // Restart: pulse the ball reset and forget the old scores so the
            // ball's clear to zero is not mistaken for a point.
            if (start_rise) begin
               state_d  = S_SERVE;
               cnt_d    = SERVE_LD;
               winner_d = WIN_NONE;
               brst_d   = 1'b0;
               p1_d     = 4'd0;
               p2_d     = 4'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, output and score-history registers with synchronous reset.
   always_ff @(posedge clk_1ms) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         winner_q <= WIN_NONE;
         gs_q     <= GS_IDLE;
         brst_q   <= 1'b0;
         p1_q     <= 4'd0;
         p2_q     <= 4'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         winner_q <= winner_d;
         gs_q     <= gs_encode(state_d);
         brst_q   <= brst_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
      end
   end

   assign bus.game_state = gs_q;
   assign bus.ball_rst_n = brst_q;
   assign bus.serve_cnt  = cnt_q;
   assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: the driver queues hand-computed
// expectations tagged with the tick they are due; a monitor on the falling
// edge pops and compares them.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  localparam int CW = 4;

  typedef struct {
    int         at;
    string      name;
    logic [1:0] gs;
    logic [1:0] win;
    int         cnt;
    logic       brst;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   ncount = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pong_match_ctrl_if #(.CNT_W(CW)) bus ();

  pong_match_ctrl #(
    .WIN_SCORE (3),
    .SERVE_MS  (5),
    .CNT_W     (CW)
  ) dut (
    .clk_1ms (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Count one check and record a failure when the condition does not hold.
  task automatic check(input string name, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s tick %0d: gs=%b win=%b cnt=%0d brst=%b",
               name, ncount, bus.game_state, bus.winner, bus.serve_cnt,
               bus.ball_rst_n);
    end
  endtask

  // Monitor: count falling edges and compare every expectation that is due.
  always @(negedge clk) begin
    exp_t e;
    ncount++;
    while (sb.size() != 0 && sb[0].at <= ncount) begin
      e = sb.pop_front();
      check(e.name, bus.game_state === e.gs && bus.winner === e.win &&
                    bus.serve_cnt === CW'(e.cnt) && bus.ball_rst_n === e.brst);
    end
  end

  // Drive point: just after a falling edge, so the next rising edge samples.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Queue an expectation k ticks ahead, kept in due order.
  task automatic expect_in(input int k, input string name, input logic [1:0] gs,
                           input logic [1:0] win, input int cnt, input logic brst);
    exp_t e;
    int   pos;
    e.at = ncount + k; e.name = name; e.gs = gs; e.win = win;
    e.cnt = cnt; e.brst = brst;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > e.at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  initial begin
    reset         = 1'b0;
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    bus.p1_score  = 4'd0;
    bus.p2_score  = 4'd0;

    // Reset held three ticks, then released.
    for (int i = 0; i < 3; i++) begin
      step();
      expect_in(1, "reset_vals", GS_IDLE, WIN_NONE, 0, 1'b0);
    end
    step();
    reset = 1'b1;
    expect_in(1, "reset_release", GS_IDLE, WIN_NONE, 0, 1'b1);

    // Start held for ten ticks: a single serve, countdown 4..0, then play.
    step();
    bus.start_btn = 1'b1;
    for (int i = 0; i < 5; i++)
      expect_in(1 + i, "serve_count", GS_IDLE, WIN_NONE, 4 - i, 1'b1);
    expect_in(6, "serve_to_play", GS_PLAY, WIN_NONE, 0, 1'b1);
    expect_in(10, "start_held_play", GS_PLAY, WIN_NONE, 0, 1'b1);
    step(10);
    bus.start_btn = 1'b0;
    step(2);

    // Player 1 scores: serve reloads, play resumes five ticks later.
    bus.p1_score = 4'd1;
    expect_in(1, "point_serve", GS_IDLE, WIN_NONE, 4, 1'b1);
    expect_in(5, "point_serve_end", GS_IDLE, WIN_NONE, 0, 1'b1);
    expect_in(6, "point_replay", GS_PLAY, WIN_NONE, 0, 1'b1);
    step(8);

    // Pause, score activity while paused is ignored, resume with no serve.
    bus.pause_btn = 1'b1;
    expect_in(1, "pause", GS_PAUSE, WIN_NONE, 0, 1'b1);
    step();
    bus.pause_btn = 1'b0;
    step();
    bus.p2_score = 4'd1;
    expect_in(1, "paused_score1", GS_PAUSE, WIN_NONE, 0, 1'b1);
    step();
    bus.p2_score = 4'd2;
    expect_in(1, "paused_score2", GS_PAUSE, WIN_NONE, 0, 1'b1);
    step();
    bus.pause_btn = 1'b1;
    expect_in(1, "resume", GS_PLAY, WIN_NONE, 0, 1'b1);
    expect_in(2, "resume_no_serve", GS_PLAY, WIN_NONE, 0, 1'b1);
    step();
    bus.pause_btn = 1'b0;
    step(3);

    // Score and pause rise on the same tick: the score path wins.
    bus.p1_score  = 4'd2;
    bus.pause_btn = 1'b1;
    expect_in(1, "score_beats_pause", GS_IDLE, WIN_NONE, 4, 1'b1);
    expect_in(6, "score_pause_replay", GS_PLAY, WIN_NONE, 0, 1'b1);
    step();
    bus.pause_btn = 1'b0;
    step(8);

    // Player 2 reaches the winning score: match over, held for 50 ticks.
    bus.p2_score = 4'd3;
    expect_in(1, "match_over", GS_OVER, WIN_P2, 0, 1'b1);
    expect_in(25, "over_hold_mid", GS_OVER, WIN_P2, 0, 1'b1);
    expect_in(51, "over_hold_end", GS_OVER, WIN_P2, 0, 1'b1);
    step(52);

    // Restart from OVER: one-tick ball reset, scores cleared, serve then play.
    bus.start_btn = 1'b1;
    expect_in(1, "restart_pulse", GS_IDLE, WIN_NONE, 4, 1'b0);
    expect_in(2, "restart_release", GS_IDLE, WIN_NONE, 3, 1'b1);
    expect_in(3, "restart_cnt2", GS_IDLE, WIN_NONE, 2, 1'b1);
    expect_in(5, "restart_cnt0", GS_IDLE, WIN_NONE, 0, 1'b1);
    expect_in(6, "restart_play", GS_PLAY, WIN_NONE, 0, 1'b1);
    expect_in(8, "restart_no_reload", GS_PLAY, WIN_NONE, 0, 1'b1);
    step();
    bus.p1_score = 4'd0;
    bus.p2_score = 4'd0;
    step();
    bus.start_btn = 1'b0;
    step(8);

    // Reset asserted mid-play forces reset values on that edge.
    reset = 1'b0;
    expect_in(1, "reset_mid_play", GS_IDLE, WIN_NONE, 0, 1'b0);
    step();
    reset = 1'b1;
    expect_in(1, "reset_mid_release", GS_IDLE, WIN_NONE, 0, 1'b1);
    step();

    // Direct checks of the outputs one tick after the final release.
    check("final_gs",   bus.game_state === GS_IDLE);
    check("final_win",  bus.winner === WIN_NONE);
    check("final_cnt",  bus.serve_cnt === CW'(0));
    check("final_brst", bus.ball_rst_n === 1'b1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared, due tick %0d, reached tick %0d",
               e.name, e.at, ncount);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
